// File: rtl/mem_vector_reader.sv
// Streams L consecutive words from scratch memory, starting at xAddr, over a valid/ready port.
// A 2-entry skid buffer absorbs the one-cycle read latency so the stream can run at one word per cycle.
module mem_vector_reader #(
  parameter int DEPTH = 2,
  parameter int AW    = 11
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] xAddr,
  input  logic [15:0]   L,
  input  logic [31:0]   memIn,
  output logic [AW-1:0] memReadAddr,
  output logic [15:0]   addOutA,
  output logic [15:0]   addOutB,
  input  logic [15:0]   addIn,
  output logic [31:0]   dataOut,
  output logic          dataValid,
  input  logic          dataReady,
  output logic          dataLast,
  output logic          busy,
  output logic          done
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

  state_t              state, state_next;
  logic [AW-1:0]       base_reg;
  logic [15:0]         len_reg;
  logic [15:0]         rd_idx;
  logic [15:0]         out_idx;
  logic [AW-1:0]       addr_hold;
  logic [15:0]         opa_hold;
  logic [15:0]         opb_hold;
  logic [AW-1:0]       addr_p0;
  logic                issue_p0;
  logic                vld_p1;
  logic [DATA_W-1:0]   skid_q [DEPTH];
  logic                wr_ptr;
  logic                rd_ptr;
  logic [1:0]          occ;
  logic [2:0]          pending;
  logic                pop;
  logic                head_last;

  assign dataValid = (occ != 2'd0);
  assign pop       = dataValid && dataReady;
  assign head_last = (out_idx == len_reg - 16'd1);
  assign dataLast  = dataValid && head_last;
  assign dataOut   = dataValid ? skid_q[rd_ptr] : '0;

  // A beat popping this cycle frees its slot, which keeps back-to-back reads going at full rate.
  assign pending  = {1'b0, occ} + {2'b0, vld_p1} - {2'b0, pop};
  assign issue_p0 = (state == READ) && (pending < 3'(DEPTH));
  assign addr_p0  = base_reg + rd_idx[AW-1:0];

  assign memReadAddr = issue_p0 ? addr_p0 : addr_hold;
  assign addOutA     = issue_p0 ? rd_idx  : opa_hold;
  assign addOutB     = issue_p0 ? 16'd1   : opb_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (L == 16'd0) ? DONE : READ;
        end
      end
      READ: begin
        busy = 1'b1;
        if (issue_p0 && (addIn == len_reg)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (pop && head_last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // p0: read issue, index advance through the shared adder
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      base_reg  <= '0;
      len_reg   <= '0;
      rd_idx    <= '0;
      addr_hold <= '0;
      opa_hold  <= '0;
      opb_hold  <= '0;
      vld_p1    <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      if (state == IDLE && start) begin
        base_reg <= xAddr;
        len_reg  <= L;
        rd_idx   <= '0;
      end
      if (issue_p0) begin
        rd_idx    <= addIn;
        addr_hold <= addr_p0;
        opa_hold  <= rd_idx;
        opb_hold  <= 16'd1;
      end
    end
  end

  // p1: returning word lands in the skid buffer; head pops on each beat
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
      out_idx <= '0;
    end else begin
      if (vld_p1) begin
        wr_ptr <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr  <= ~rd_ptr;
        out_idx <= out_idx + 16'd1;
      end
      if (state == IDLE && start) begin
        out_idx <= '0;
      end
      occ <= occ + {1'b0, vld_p1} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (vld_p1) begin
      skid_q[wr_ptr] <= memIn;
    end
  end

endmodule

// File: tb/tb_mem_vector_reader.sv
// Directed bench for mem_vector_reader: table of stream runs plus reset-abort and start-ignore sequences.
// Memory and the shared adder are modelled here; expected words come from the bench's own preload.
module tb_mem_vector_reader;

  localparam int AW = 11;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] xAddr;
  logic [15:0]   L;
  logic [31:0]   memIn;
  logic [AW-1:0] memReadAddr;
  logic [15:0]   addOutA;
  logic [15:0]   addOutB;
  logic [15:0]   addIn;
  logic [31:0]   dataOut;
  logic          dataValid;
  logic          dataReady;
  logic          dataLast;
  logic          busy;
  logic          done;

  logic [31:0]   mem [2048];
  logic [AW-1:0] addr_log [64];
  logic [AW-1:0] wrap_exp [4];
  int            n_vec;
  int            n_bad;

  typedef struct {
    logic [AW-1:0] xaddr;
    logic [15:0]   len;
    logic [3:0]    pat;        // dataReady for cycle c is pat[c % 4]
    int            restart_at; // cycle of an extra start pulse (0 = none)
    logic [31:0]   exp_first;
    logic [31:0]   exp_last;
    int            exp_vld;    // cycle of first dataValid, -1 = never
    int            exp_done;   // cycle of done pulse, 0 = not checked
    bit            chk_wrap;
  } vec_t;

  vec_t tbl [6];
  vec_t rst_vec;

  mem_vector_reader #(.DEPTH(2), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .xAddr       (xAddr),
    .L           (L),
    .memIn       (memIn),
    .memReadAddr (memReadAddr),
    .addOutA     (addOutA),
    .addOutB     (addOutB),
    .addIn       (addIn),
    .dataOut     (dataOut),
    .dataValid   (dataValid),
    .dataReady   (dataReady),
    .dataLast    (dataLast),
    .busy        (busy),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign addIn = addOutA + addOutB;
  always @(posedge clk) memIn <= mem[memReadAddr];

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk(dataValid == 1'b0, {tag, "_dataValid"}, 32'(dataValid), 0);
    chk(dataLast == 1'b0, {tag, "_dataLast"}, 32'(dataLast), 0);
    chk(done == 1'b0, {tag, "_done"}, 32'(done), 0);
    chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 0);
    chk(dataOut == 32'd0, {tag, "_dataOut"}, dataOut, 0);
    chk(memReadAddr == '0, {tag, "_memReadAddr"}, 32'(memReadAddr), 0);
    chk(addOutA == 16'd0, {tag, "_addOutA"}, 32'(addOutA), 0);
    chk(addOutB == 16'd0, {tag, "_addOutB"}, 32'(addOutB), 0);
  endtask

  // Called right after a rising edge; returns right after a rising edge.
  task automatic run_vec(input vec_t v);
    int          cyc;
    int          beats;
    int          first_vld;
    int          done_cyc;
    int          ahead;
    int          idx;
    bit          stall_q;
    logic [31:0] stall_data;
    logic [31:0] exp;
    logic [AW-1:0] addr0;
    cyc = 0; beats = 0; first_vld = -1; done_cyc = -1; stall_q = 0; stall_data = '0;
    addr0 = memReadAddr;
    xAddr = v.xaddr; L = v.len; start = 1'b1; dataReady = v.pat[0];
    while (done_cyc < 0 && cyc < 200) begin
      @(negedge clk);
      if (cyc < 64) addr_log[cyc] = memReadAddr;
      if (stall_q) begin
        chk(dataValid == 1'b1, "stall_valid", 32'(dataValid), 1);
        chk(dataOut == stall_data, "stall_data", dataOut, stall_data);
      end
      if (dataValid && first_vld < 0) first_vld = cyc;
      if (busy && cyc > 0) begin
        ahead = int'(addOutA) + 1 - beats - ((dataValid && dataReady) ? 1 : 0);
        chk(ahead <= 2, "read_ahead", ahead, 2);
        chk(addOutB == 16'd1, "add_opB", 32'(addOutB), 1);
      end
      if (v.len == 16'd0) begin
        chk(memReadAddr == addr0, "no_read_addr", 32'(memReadAddr), 32'(addr0));
        chk(busy == 1'b0, "zero_len_busy", 32'(busy), 0);
      end
      if (dataValid && dataReady) begin
        if (beats >= int'(v.len)) begin
          chk(1'b0, "extra_beat", dataOut, 0);
        end else begin
          idx = (int'(v.xaddr) + beats) % 2048;
          if (beats == 0) exp = v.exp_first;
          else if (beats == int'(v.len) - 1) exp = v.exp_last;
          else exp = mem[idx];
          chk(dataOut == exp, "beat_data", dataOut, exp);
          chk(dataLast == (beats == int'(v.len) - 1), "last_flag", 32'(dataLast),
              32'(beats == int'(v.len) - 1));
        end
        beats++;
      end
      stall_q = dataValid && !dataReady;
      stall_data = dataOut;
      if (done) begin
        done_cyc = cyc;
        chk(busy == 1'b0, "busy_at_done", 32'(busy), 0);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      dataReady = v.pat[cyc % 4];
      if (v.restart_at != 0 && cyc == v.restart_at) begin
        start = 1'b1; xAddr = 11'd500; L = 16'd2;
      end
    end
    if (done_cyc < 0) chk(1'b0, "done_timeout", cyc, 0);
    chk(beats == int'(v.len), "beat_count", beats, 32'(v.len));
    chk(first_vld == v.exp_vld, "first_valid_cycle", first_vld, v.exp_vld);
    if (v.exp_done > 0) chk(done_cyc == v.exp_done, "done_cycle", done_cyc, v.exp_done);
    if (v.chk_wrap) begin
      for (int k = 0; k < 4; k++) begin
        chk(addr_log[k + 1] == wrap_exp[k], "wrap_addr", 32'(addr_log[k + 1]), 32'(wrap_exp[k]));
      end
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk(!done && !busy && !dataValid, "post_idle", {29'd0, done, busy, dataValid}, 0);
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    int iter;
    n_vec = 0; n_bad = 0;
    for (int a = 0; a < 2048; a++) mem[a] = 32'hC0DE0000 | 32'(a);
    for (int a = 0; a < 10; a++) mem[16 + a] = 32'(a);
    mem[2046] = 32'hA; mem[2047] = 32'hB; mem[0] = 32'hC; mem[1] = 32'hD;
    wrap_exp[0] = 11'd2046; wrap_exp[1] = 11'd2047; wrap_exp[2] = 11'd0; wrap_exp[3] = 11'd1;

    //           xaddr     len     pat      rst first            last             vld done wrap
    tbl[0] = '{11'd16,   16'd10, 4'b1111, 0, 32'h0,           32'h9,           3, 13, 1'b0};
    tbl[1] = '{11'd100,  16'd0,  4'b1111, 0, 32'h0,           32'h0,          -1,  1, 1'b0};
    tbl[2] = '{11'd16,   16'd8,  4'b1001, 0, 32'h0,           32'h7,           3,  0, 1'b0};
    tbl[3] = '{11'd2046, 16'd4,  4'b1111, 0, 32'hA,           32'hD,           3,  7, 1'b1};
    tbl[4] = '{11'd16,   16'd10, 4'b1111, 5, 32'h0,           32'h9,           3, 13, 1'b0};
    tbl[5] = '{11'd30,   16'd3,  4'b0101, 0, 32'hC0DE001E,    32'hC0DE0020,    3,  0, 1'b0};
    rst_vec = '{11'd16,  16'd3,  4'b1111, 0, 32'h0,           32'h2,           3,  6, 1'b0};

    reset = 1'b0; start = 1'b0; dataReady = 1'b0; xAddr = '0; L = '0;
    #2;
    chk_zero_outputs("reset_state");
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++) run_vec(tbl[t]);

    // Abort with reset after four beats have been accepted.
    xAddr = 11'd16; L = 16'd10; start = 1'b1; dataReady = 1'b1;
    cnt = 0; iter = 0;
    while (cnt < 4 && iter < 50) begin
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      if (dataValid && dataReady) cnt++;
      iter++;
    end
    chk(cnt == 4, "reset_setup_beats", cnt, 4);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk(!done && !busy, "held_in_reset", {30'd0, done, busy}, 0);
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk(!done && !dataValid, "no_done_after_reset", {30'd0, done, dataValid}, 0);
    end
    @(posedge clk); #1;
    run_vec(rst_vec);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_vector_reader.md
Name: mem_vector_reader

Overview:
- Reads a vector of L 32-bit words from scratch memory, starting at base address xAddr.
- Streams the words in order to a downstream consumer over a valid/ready handshake.
- It is the read-side counterpart to the scratch-memory writer/loader path, so a memory vector can drain into a serial consumer (bitstream packer, checker) without CPU-style sequencing.
- It shares the scratch memory read port (one-cycle read latency) and the external 16-bit add unit, in the same way as the other G.729 math blocks.

Parameters:
- DEPTH, 2, skid-buffer entries covering the one-cycle memory latency (fixed at 2; other values unsupported).
- AW, 11, scratch memory address width.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; latches xAddr and L; ignored unless idle.
- xAddr  in  11  vector base address.
- L  in  16  word count (unsigned, 0..65535).
- memIn  in  32  scratch memory read data; valid the cycle after memReadAddr is presented.
- memReadAddr  out  11  scratch memory read address.
- addOutA  out  16  operand A to the shared add unit (index).
- addOutB  out  16  operand B to the shared add unit (constant 1).
- addIn  in  16  sum returned from the shared add unit (combinational).
- dataOut  out  32  streamed word.
- dataValid  out  1  dataOut holds a valid word.
- dataReady  in  1  consumer accepts; a beat transfers on an edge where dataValid and dataReady are both high.
- dataLast  out  1  high together with dataValid on word L-1.
- busy  out  1  high from the start acceptance until done.
- done  out  1  one-cycle pulse when the operation ends.

Behaviour:
- Reset (reset low, asynchronous): state IDLE, index and count cleared, buffer emptied.
  - Outputs return to: dataValid=0, dataLast=0, done=0, busy=0, dataOut=0, memReadAddr=0, addOutA=0, addOutB=0.
  - Reset mid-operation aborts immediately. Any in-flight memory read is discarded, and no done pulse is generated.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - On start=1, latch xAddr into baseReg and L into lenReg, and clear the read index rdIdx.
  - If L=0, go to DONE. Otherwise go to READ and set busy=1.
- READ:
  - Issues a read with memReadAddr = baseReg + rdIdx (mod 2^11, so addresses wrap 2047 to 0).
  - A read is issued only when (buffer occupancy + reads in flight) < 2.
  - On issue: addOutA=rdIdx, addOutB=1, and rdIdx <= addIn.
  - When rdIdx reaches lenReg after an issue, go to DRAIN.
  - When no read is issued, memReadAddr holds its last value and addOutA/addOutB hold.
- Capture path: the word returned on memIn in the cycle after an issue is written into the 2-entry FIFO skid buffer. Words are never dropped or reordered.
- Output:
  - dataValid = buffer not empty; dataOut = head entry.
  - dataLast = 1 when the head entry is word lenReg-1, tracked by a 16-bit output counter outIdx.
  - A beat pops the head entry and increments outIdx.
  - dataOut and dataValid are held stable while dataValid=1 and dataReady=0.
- DRAIN: issues no reads. When the last beat transfers, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE.
- Start while busy is ignored, with no effect on latched values.
- Latency with dataReady held high:
  - start sampled at edge 0.
  - First read address is driven after edge 0.
  - First dataValid after edge 2.
  - One beat per cycle after that.
  - done pulse in the cycle after the last beat's edge, so for L words done is high in cycle L+3.
- Throughput: sustained at 1 word/cycle with dataReady=1. While dataReady=0 the buffer fills to 2 and reads stall.
- Simultaneous capture and pop in the same cycle is allowed: occupancy is unchanged, and FIFO order is preserved.
- Wrap-around is legal for L > 2048: words repeat modulo memory size.

Test Plan:
- Preload words 0x00000000..0x00000009 at addresses 16..25; start with xAddr=16, L=10, dataReady=1 -> 10 consecutive beats with values 0x0..0x9, first dataValid 3 cycles after start, dataLast only on 0x9, done one cycle later, busy low afterwards.
- L=0, xAddr=100 -> no dataValid, no memory reads, done pulses the cycle after start, busy stays 0.
- L=8, dataReady toggling 1,0,0,1 repeating -> all 8 words delivered in order with no duplicates; dataOut stable during stalls; memReadAddr never more than 2 words ahead of the last accepted beat.
- Preload 0xA..0xD at addresses 2046, 2047, 0, 1; xAddr=2046, L=4 -> memReadAddr sequence 2046, 2047, 0, 1; beats 0xA, 0xB, 0xC, 0xD.
- Start L=10; pulse reset low after 4 beats -> all outputs go to 0 immediately with no done pulse; a new start with L=3 then streams the correct 3 words.
- Start xAddr=16, L=10; pulse start again with xAddr=500, L=2 mid-stream -> second start ignored; original 10 words delivered, then a single done pulse.
